jtag_port_gen: RTL

- Parametrised successor JTAG-style debug port, clocked entirely by TCK.
- Parses TMS/TDI into command and data shift registers.
- Reports uP status on command capture and captures core read-data on data capture.
- Issues validated {cmd, data} requests to the debug controller over a req/ack handshake, with overrun and length checking the previous generation lacked.

---
 rtl/jtag_port_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/jtag_port_gen.sv
// JTAG-style debug port: parses TMS/TDI into command/data shift registers and issues {cmd,data} requests.
// Latency: a request appears on o_req one i_TCK edge after the UPDATE state; TDO is combinational.
// Backpressure: one request outstanding; a valid update while o_req=1 without i_ack is dropped and sets sticky overrun.
//
// Ports:
//   i_TCK, i_rstn       : sole clock, asynchronous active-low reset
//   i_TMS, i_TDI, o_TDO : JTAG serial interface (TDO shifts MSB-first)
//   i_status, i_rdData  : core status (loaded on command capture), core read-back (loaded on data capture)
//   o_req/o_cmd/o_data  : pending request to the debug controller, accepted by i_ack
module jtag_port_gen #(
    parameter int CMD_W    = 8,   // must be >= STATUS_W+2
    parameter int DATA_W   = 16,
    parameter int STATUS_W = 2
) (
    input  logic                i_TCK,
    input  logic                i_rstn,
    input  logic                i_TMS,
    input  logic                i_TDI,
    output logic                o_TDO,
    input  logic [STATUS_W-1:0] i_status,
    input  logic [DATA_W-1:0]   i_rdData,
    output logic                o_req,
    output logic [CMD_W-1:0]    o_cmd,
    output logic [DATA_W-1:0]   o_data,
    input  logic                i_ack
);

    localparam int MAX_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    // Two spare codes above the longest legal length so saturation never lands on a valid count.
    localparam int CNT_W = $clog2(MAX_W + 2);

    localparam logic [CNT_W-1:0] CMD_LEN  = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] DATA_LEN = CNT_W'(DATA_W);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] I_SEL  = 3'd1;
    localparam logic [2:0] I_SHFT = 3'd2;
    localparam logic [2:0] D_SEL  = 3'd3;
    localparam logic [2:0] D_SHFT = 3'd4;
    localparam logic [2:0] UPDATE = 3'd5;

    logic [2:0]        state;
    logic [2:0]        stateNxt;
    logic [CMD_W-1:0]  cmdReg;
    logic [CMD_W-1:0]  cmdCap;
    logic [DATA_W-1:0] dataReg;
    logic [CNT_W-1:0]  bitCnt;
    logic [CNT_W-1:0]  bitCntInc;
    logic              pathData;   // 1 when the current shift came through the data path
    logic              overrun;
    logic              lenOk;
    logic              updValid;
    logic              updAccept;

    always_comb begin
        stateNxt = IDLE;
        case (state)
            IDLE:    stateNxt = i_TMS ? I_SEL  : IDLE;
            I_SEL:   stateNxt = i_TMS ? D_SEL  : I_SHFT;
            I_SHFT:  stateNxt = i_TMS ? UPDATE : I_SHFT;
            D_SEL:   stateNxt = i_TMS ? IDLE   : D_SHFT;
            D_SHFT:  stateNxt = i_TMS ? UPDATE : D_SHFT;
            UPDATE:  stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Status word read out on command capture: {zeros, overrun, req, status}.
    always_comb begin
        cmdCap                 = '0;
        cmdCap[STATUS_W+1:0]   = {overrun, o_req, i_status};
    end

    assign bitCntInc = (bitCnt == '1) ? bitCnt : bitCnt + CNT_W'(1);

    assign lenOk     = pathData ? (bitCnt == DATA_LEN) : (bitCnt == CMD_LEN);
    assign updValid  = (state == UPDATE) && lenOk;
    // An ack arriving on the update edge frees the slot for the new request.
    assign updAccept = updValid && (!o_req || i_ack);

    assign o_TDO = (state == D_SHFT) ? dataReg[DATA_W-1] : cmdReg[CMD_W-1];

    always_ff @(posedge i_TCK or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            cmdReg   <= '0;
            dataReg  <= '0;
            bitCnt   <= '0;
            pathData <= 1'b0;
            overrun  <= 1'b0;
            o_req    <= 1'b0;
            o_cmd    <= '0;
            o_data   <= '0;
        end else begin
            state <= stateNxt;

            case (state)
                I_SEL: begin
                    if (!i_TMS) begin
                        cmdReg   <= cmdCap;
                        overrun  <= 1'b0;   // read-to-clear
                        bitCnt   <= '0;
                        pathData <= 1'b0;
                    end
                end
                D_SEL: begin
                    if (!i_TMS) begin
                        dataReg  <= i_rdData;
                        bitCnt   <= '0;
                        pathData <= 1'b1;
                    end
                end
                I_SHFT: begin
                    cmdReg <= {cmdReg[CMD_W-2:0], i_TDI};
                    bitCnt <= bitCntInc;
                end
                D_SHFT: begin
                    dataReg <= {dataReg[DATA_W-2:0], i_TDI};
                    bitCnt  <= bitCntInc;
                end
                default: ;
            endcase

            if (updAccept) begin
                o_cmd  <= cmdReg;
                o_data <= dataReg;
                o_req  <= 1'b1;
            end else if (updValid) begin
                overrun <= 1'b1;
            end else if (o_req && i_ack) begin
                o_req <= 1'b0;
            end
        end
    end

endmodule
